// File: rtl/reg_read_sequencer.sv
// reg_read_sequencer
//
// Read-side master for a small register file. A start request in IDLE
// launches a run of consecutive register reads (wrapping modulo NUM_REGS).
// Each word is fetched through the file's read port, captured, and offered
// downstream on a valid/ready stream. A one-cycle done pulse marks the end
// of the run.
//
// Each word walks ISSUE -> WAIT -> PRESENT. The read strobe is raised in
// ISSUE. The file returns data one cycle later, during WAIT. That data is
// captured on the WAIT -> PRESENT edge.
//
// Optional feature: define RD_SEQ_PARITY_EN to add out_parity. It is the XOR
// reduction of out_data and is registered together with out_data.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   run request, sampled only in IDLE
//   base_addr  in   first register address of the run
//   count      in   words in the run (0 or > NUM_REGS means NUM_REGS)
//   busy       out  high in every state except IDLE
//   rd_en      out  read strobe to the register file (ISSUE only)
//   rd_addr    out  read address (address pointer)
//   rd_data    in   register file read data, valid the cycle after rd_en
//   out_data   out  captured word
//   out_valid  out  out_data valid (PRESENT only)
//   out_parity out  even parity of out_data (RD_SEQ_PARITY_EN only)
//   out_ready  in   downstream ready
//   done       out  one-cycle pulse after the last word is accepted

module reg_read_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef RD_SEQ_PARITY_EN
  output logic              out_parity,
`endif
  input  logic              out_ready,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(NUM_REGS);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [ADDR_W:0]   count_sat;

  // Zero and out-of-range counts both mean "whole file".
  assign count_sat = ((count == '0) || (count > FULL_COUNT)) ? FULL_COUNT : count;

  assign rd_addr = addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      out_data      <= '0;
`ifdef RD_SEQ_PARITY_EN
      out_parity    <= 1'b0;
`endif
      rd_en         <= 1'b0;
      out_valid     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_ISSUE;
            addr_reg      <= base_addr;
            remaining_reg <= count_sat;
            rd_en         <= 1'b1;
            busy          <= 1'b1;
          end
        end

        S_ISSUE: begin
          state_reg <= S_WAIT;
          rd_en     <= 1'b0;
        end

        // The file presents rd_data during this cycle; capture it now.
        S_WAIT: begin
          state_reg <= S_PRESENT;
          out_data  <= rd_data;
`ifdef RD_SEQ_PARITY_EN
          out_parity <= ^rd_data;
`endif
          out_valid <= 1'b1;
        end

        // Hold here for as long as downstream stalls. out_data is untouched.
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining_reg > (ADDR_W+1)'(1)) begin
              state_reg     <= S_ISSUE;
              // The pointer is exactly ADDR_W bits wide, so it wraps modulo NUM_REGS.
              addr_reg      <= addr_reg + ADDR_W'(1);
              remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
              rd_en         <= 1'b1;
            end else begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_sequencer.sv
// Testbench for reg_read_sequencer.
//
// A behavioural 4 x 8 register file answers read strobes one cycle later.
// Inputs are driven on the falling edge. Outputs are also sampled on the
// falling edge, so the bench always sees the state left by the preceding
// rising edge. Cycle k means the k-th falling edge after the edge that
// accepted start.

module tb_reg_read_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] base_addr = 2'd0;
  logic [2:0] count = 3'd0;
  logic       busy;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       done;
`ifdef RD_SEQ_PARITY_EN
  logic       out_parity;
`endif

  logic [7:0] regs [4];

  int n_cmp = 0;
  int n_err = 0;

  // Per-run observations
  logic [7:0] word_q [$];
  int         wcyc_q [$];
  logic [1:0] addr_q [$];
  logic       par_q  [$];
  int         done_cnt;
  int         done_cyc;
  int         idle_cyc;

  reg_read_sequencer #(.DATA_W(8), .ADDR_W(2), .NUM_REGS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef RD_SEQ_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file read port: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= regs[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, expv);
    end
  endtask

  // Start a run on the next rising edge and watch it until busy drops.
  // A non-zero stall_len withholds out_ready for that many cycles at the first PRESENT.
  // restart_mid pulses start again during cycle 4.
  task automatic run(input logic [1:0] base, input logic [2:0] cnt,
                     input int stall_len, input bit restart_mid);
    int stall_left;
    logic [7:0] held;
    word_q.delete(); wcyc_q.delete(); addr_q.delete(); par_q.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1;
    stall_left = stall_len;
    held = 8'h00;
    base_addr = base; count = cnt; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = ~base;  // must be ignored after acceptance
    count = 3'd1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (restart_mid) start = (cyc == 4);
      if (rd_en) addr_q.push_back(rd_addr);
      if (out_valid) begin
        if (stall_left > 0) begin
          if (stall_left == stall_len) held = out_data;
          else check("stall_data_hold", out_data, held);
          check("stall_no_read", rd_en, 0);
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          word_q.push_back(out_data);
          wcyc_q.push_back(cyc);
`ifdef RD_SEQ_PARITY_EN
          par_q.push_back(out_parity);
`endif
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && !busy) begin
        idle_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("run_completed", (idle_cyc > 0), 1);
    $display("run base=%0d count=%0d stall=%0d: words=%0d done_cnt=%0d done_cyc=%0d idle_cyc=%0d",
             base, cnt, stall_len, word_q.size(), done_cnt, done_cyc, idle_cyc);
  endtask

  task automatic check_words(input string tag, input int n, input int expw [4]);
    check({tag, "_nwords"}, word_q.size(), n);
    for (int i = 0; i < n && i < word_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), word_q[i], expw[i]);
  endtask

  initial begin
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
`ifdef RD_SEQ_PARITY_EN
    check("rst_out_parity", out_parity, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Full run, no stall
    run(2'd0, 3'd4, 0, 1'b0);
    check_words("full", 4, '{32'h11, 32'h22, 32'h33, 32'h44});
    for (int i = 0; i < 4 && i < wcyc_q.size(); i++)
      check($sformatf("full_cycle%0d", i), wcyc_q[i], 3 * (i + 1));
    check("full_done_cnt", done_cnt, 1);
    check("full_done_cyc", done_cyc, 13);
    check("full_idle_cyc", idle_cyc, 14);

    // Wrap-around
    run(2'd3, 3'd3, 0, 1'b0);
    check_words("wrap", 3, '{32'h44, 32'h11, 32'h22, 32'h0});
    check("wrap_naddr", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      check("wrap_addr0", addr_q[0], 3);
      check("wrap_addr1", addr_q[1], 0);
      check("wrap_addr2", addr_q[2], 1);
    end
    check("wrap_done_cnt", done_cnt, 1);

    // Backpressure: 5 stall cycles at the first PRESENT
    run(2'd1, 3'd2, 5, 1'b0);
    check_words("bp", 2, '{32'h22, 32'h33, 32'h0, 32'h0});
    if (wcyc_q.size() == 2) begin
      check("bp_cycle0", wcyc_q[0], 8);
      check("bp_cycle1", wcyc_q[1], 11);
    end
    check("bp_nreads", addr_q.size(), 2);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_done_cyc", done_cyc, 12);

    // count=0 saturates; a mid-run start is ignored
    run(2'd0, 3'd0, 0, 1'b1);
    check_words("sat", 4, '{32'h11, 32'h22, 32'h33, 32'h44});
    check("sat_done_cnt", done_cnt, 1);
    check("sat_done_cyc", done_cyc, 13);
    @(negedge clk);
    check("sat_no_restart", busy, 0);

    // count above NUM_REGS saturates too
    run(2'd2, 3'd7, 0, 1'b0);
    check_words("sat7", 4, '{32'h33, 32'h44, 32'h11, 32'h22});

    // count=1 gives a single word
    run(2'd2, 3'd1, 0, 1'b0);
    check_words("single", 1, '{32'h33, 32'h0, 32'h0, 32'h0});
    check("single_done_cyc", done_cyc, 4);

    // Reset during the second WAIT (cycle 5)
    base_addr = 2'd0; count = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 0);
      check("mid_rst_no_valid", out_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    run(2'd0, 3'd4, 0, 1'b0);
    check_words("post_rst", 4, '{32'h11, 32'h22, 32'h33, 32'h44});
    check("post_rst_done_cyc", done_cyc, 13);

`ifdef RD_SEQ_PARITY_EN
    regs[0] = 8'h07; regs[1] = 8'h03;
    run(2'd0, 3'd2, 0, 1'b0);
    check_words("par", 2, '{32'h07, 32'h03, 32'h0, 32'h0});
    check("par_n", par_q.size(), 2);
    if (par_q.size() == 2) begin
      check("par_word0", par_q[0], 1);
      check("par_word1", par_q[1], 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
